// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display reader.
// Contents: segment/nibble widths, the active-low {g..a} hex font and the
// filter FSM state type.
package seven_seg_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned FONT_N   = 16;

  // Active-low {g,f,e,d,c,b,a} pattern for hex value i at index i.
  localparam logic [SEG_W-1:0] FONT [FONT_N] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    SETTLING = 1'b0,
    LOCKED   = 1'b1
  } filt_state_e;

endpackage

// File: rtl/seg_pattern_to_hex.sv
// Inverse font lookup: maps an active-low 7-segment pattern to its hex value.
// Ports:
//   pattern  in  SEG_W     active-low {g..a}
//   value    out NIBBLE_W  decoded nibble (0 when no match)
//   hit      out 1         pattern is a font entry
module seg_pattern_to_hex
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0]    pattern,
  output logic [NIBBLE_W-1:0] value,
  output logic                hit
);

  always_comb begin
    value = '0;
    hit   = 1'b0;
    for (int unsigned i = 0; i < FONT_N; i++) begin
      if (pattern == FONT[i]) begin
        value = NIBBLE_W'(i);
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Recovers the hex digits shown on a scanned, multiplexed 7-segment bus.
// Inputs are synchronised, ghosting is filtered by a stability counter, each
// settled one-hot digit is inverse-decoded into a working slot, and a full set
// of slots is handed to the consumer over valid/ready.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   seg_n [SEG_W]        active-low segments {g..a}
//   an_n  [NUM_DIGITS]   active-low digit enables
//   digits               captured frame, digit i at [4i+3:4i]
//   frame_valid/ready    frame handshake
//   pattern_err          one-cycle pulse on a settled non-font pattern
//   overrun              sticky, a completed frame was dropped
// Optional: SEVEN_SEG_READER_DP_EN adds dp_n (in) and dps (out, active-high).
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [SEG_W-1:0]               seg_n,
  input  logic [NUM_DIGITS-1:0]          an_n,
`ifdef SEVEN_SEG_READER_DP_EN
  input  logic                           dp_n,
  output logic [NUM_DIGITS-1:0]          dps,
`endif
  output logic [NIBBLE_W*NUM_DIGITS-1:0] digits,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic                           pattern_err,
  output logic                           overrun
);

`ifdef SEVEN_SEG_READER_DP_EN
  localparam int unsigned DP_W = 1;
`else
  localparam int unsigned DP_W = 0;
`endif
  localparam int unsigned S_W   = DP_W + NUM_DIGITS + SEG_W;
  localparam int unsigned CNT_W = 8;

  logic [S_W-1:0] raw;
`ifdef SEVEN_SEG_READER_DP_EN
  assign raw = {dp_n, an_n, seg_n};
`else
  assign raw = {an_n, seg_n};
`endif

  logic [SYNC_STAGES-1:0][S_W-1:0]        sync_q, sync_d;
  logic [S_W-1:0]                         prev_q, prev_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  filt_state_e                            state_q, state_d;
  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0]    slots_q, slots_d;
  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0]    digits_q, digits_d;
  logic [NUM_DIGITS-1:0]                  mask_q, mask_d;
  logic                                   frame_valid_q, frame_valid_d;
  logic                                   pattern_err_q, pattern_err_d;
  logic                                   overrun_q, overrun_d;
`ifdef SEVEN_SEG_READER_DP_EN
  logic [NUM_DIGITS-1:0]                  dp_slots_q, dp_slots_d;
  logic [NUM_DIGITS-1:0]                  dps_q, dps_d;
`endif

  logic [S_W-1:0]        s;
  logic [SEG_W-1:0]      s_seg;
  logic [NUM_DIGITS-1:0] an_lit;
  logic                  an_onehot;
  logic [NIBBLE_W-1:0]   hex_val;
  logic                  hex_hit;
  logic                  capture;
  logic                  handshake;

  assign s      = sync_q[SYNC_STAGES-1];
  assign s_seg  = s[SEG_W-1:0];
  assign an_lit = ~s[SEG_W +: NUM_DIGITS];
  // Exactly one enable low: non-zero and a power of two.
  assign an_onehot = (an_lit != '0) &&
                     ((an_lit & (an_lit - NUM_DIGITS'(1))) == '0);

  seg_pattern_to_hex u_decode (
    .pattern (s_seg),
    .value   (hex_val),
    .hit     (hex_hit)
  );

  // Synchroniser shift: stage 0 takes the pins, last stage is the sample S.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};

  // Stability filter: one capture per settled sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = s;
    capture = 1'b0;
    case (state_q)
      SETTLING: begin
        if (s == prev_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STABLE_CYCLES - 2)) begin
            capture = 1'b1;
            state_d = LOCKED;
          end
        end else begin
          cnt_d = '0;
        end
      end
      LOCKED: begin
        if (s != prev_q) begin
          cnt_d   = '0;
          state_d = SETTLING;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SETTLING;
      end
    endcase
  end

  // Collector and frame handshake; a capture in the transfer cycle lands in
  // the new frame because it is ORed in after the mask clear.
  always_comb begin
    slots_d       = slots_q;
    mask_d        = mask_q;
    digits_d      = digits_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    pattern_err_d = 1'b0;
`ifdef SEVEN_SEG_READER_DP_EN
    dp_slots_d    = dp_slots_q;
    dps_d         = dps_q;
`endif
    handshake = frame_valid_q && frame_ready;

    if (handshake) begin
      frame_valid_d = 1'b0;
      overrun_d     = 1'b0;
    end

    if (&mask_q) begin
      mask_d = '0;
      if (!frame_valid_q || handshake) begin
        digits_d      = slots_q;
        frame_valid_d = 1'b1;
`ifdef SEVEN_SEG_READER_DP_EN
        dps_d         = dp_slots_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (capture && an_onehot) begin
      if (hex_hit) begin
        mask_d = mask_d | an_lit;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (an_lit[i]) begin
            slots_d[i] = hex_val;
`ifdef SEVEN_SEG_READER_DP_EN
            dp_slots_d[i] = ~s[S_W-1];
`endif
          end
        end
      end else begin
        pattern_err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q        <= '1;
      prev_q        <= '0;
      cnt_q         <= '0;
      state_q       <= SETTLING;
      slots_q       <= '0;
      mask_q        <= '0;
      digits_q      <= '0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef SEVEN_SEG_READER_DP_EN
      dp_slots_q    <= '0;
      dps_q         <= '0;
`endif
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      slots_q       <= slots_d;
      mask_q        <= mask_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      pattern_err_q <= pattern_err_d;
      overrun_q     <= overrun_d;
`ifdef SEVEN_SEG_READER_DP_EN
      dp_slots_q    <= dp_slots_d;
      dps_q         <= dps_d;
`endif
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign pattern_err = pattern_err_q;
  assign overrun     = overrun_q;
`ifdef SEVEN_SEG_READER_DP_EN
  assign dps         = dps_q;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: expected frames are queued as
// digits are driven and compared when a new frame appears on the outputs.
`timescale 1ns/1ps
module tb_seven_seg_reader;

  localparam logic [6:0] FONT_T [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] DIG_AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic        frame_ready = 1'b0;
  logic [15:0] digits;
  logic        frame_valid;
  logic        pattern_err;
  logic        overrun;
`ifdef SEVEN_SEG_READER_DP_EN
  logic        dp_n = 1'b1;
  logic [3:0]  dps;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int pe_cnt = 0;
  int pe0;
  int first_k;
  logic [15:0] exp_q [$];
  logic fv_prev = 1'b0;
  logic hs_prev = 1'b0;

  seven_seg_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
`ifdef SEVEN_SEG_READER_DP_EN
    .dp_n        (dp_n),
    .dps         (dps),
`endif
    .digits      (digits),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .pattern_err (pattern_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive pins (caller sits just after a rising edge) and hold for cyc edges.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cyc);
    an_n  = an;
    seg_n = seg;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic show_digit(input int idx, input int val);
    drive(DIG_AN[idx], FONT_T[val], 12);
  endtask

  task automatic accept_one();
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
  endtask

  // Output monitor: count error pulses and score each newly presented frame.
  always @(negedge clk) begin
    if (!reset_n) begin
      fv_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (pattern_err) pe_cnt++;
      if (frame_valid && (!fv_prev || hs_prev)) begin
        check_eq("frame_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("frame_digits", 32'(digits), 32'(exp_q.pop_front()));
      end
      fv_prev = frame_valid;
      hs_prev = frame_valid && frame_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_digits", 32'(digits), 32'd0);
    check_eq("rst_valid", 32'(frame_valid), 32'd0);
    check_eq("rst_perr", 32'(pattern_err), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    drive(4'hF, 7'h7F, 4);

    // Basic frame plus capture latency from the pin edge
    exp_q.push_back(16'hF312);
    an_n = 4'b1110;
    seg_n = 7'h24;
    first_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (dut.mask_q[0] && first_k == 0) first_k = k;
    end
    check_eq("cap_latency", 32'(first_k), 32'd10);
    show_digit(1, 1);
    show_digit(2, 3);
    show_digit(3, 15);
    check_eq("f1_valid", 32'(frame_valid), 32'd1);
    accept_one();
    check_eq("f1_released", 32'(frame_valid), 32'd0);

    // Ghosting faster than the filter window
    pe0 = pe_cnt;
    for (int r = 0; r < 8; r++) drive(4'b1110, (r % 2) ? 7'h79 : 7'h40, 5);
    drive(4'hF, 7'h7F, 12);
    check_eq("ghost_mask", 32'(dut.mask_q), 32'd0);
    check_eq("ghost_valid", 32'(frame_valid), 32'd0);
    check_eq("ghost_perr", 32'(pe_cnt - pe0), 32'd0);

    // Pattern not in the font
    pe0 = pe_cnt;
    drive(4'b1101, 7'h7F, 14);
    check_eq("bad_pat_perr", 32'(pe_cnt - pe0), 32'd1);
    check_eq("bad_pat_mask", 32'(dut.mask_q), 32'd0);

    // Multi-hot and blank enables are ignored
    pe0 = pe_cnt;
    drive(4'b1100, 7'h00, 14);
    drive(4'b1111, 7'h00, 14);
    check_eq("multihot_perr", 32'(pe_cnt - pe0), 32'd0);
    check_eq("multihot_mask", 32'(dut.mask_q), 32'd0);

    // Two frames without consumer: first held, second dropped
    exp_q.push_back(16'h3210);
    for (int d = 0; d < 4; d++) show_digit(d, d);
    for (int d = 0; d < 4; d++) show_digit(d, 8 + d);
    check_eq("ovr_set", 32'(overrun), 32'd1);
    check_eq("ovr_valid", 32'(frame_valid), 32'd1);
    check_eq("ovr_held", 32'(digits), 32'h3210);
    accept_one();
    check_eq("ovr_valid_clr", 32'(frame_valid), 32'd0);
    check_eq("ovr_clr", 32'(overrun), 32'd0);

    // Reset mid-frame discards the partial frame
    for (int d = 0; d < 3; d++) show_digit(d, 12 + d);
    reset_n = 1'b0;
    an_n = DIG_AN[3];
    seg_n = FONT_T[15];
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    show_digit(3, 15);
    check_eq("rst_mid_mask", 32'(dut.mask_q), 32'h8);
    check_eq("rst_mid_valid", 32'(frame_valid), 32'd0);
    check_eq("rst_mid_digits", 32'(digits), 32'd0);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Reads a scanned, multiplexed 7-segment display bus (active-low segments plus active-low digit enables) and recovers the hex value shown on each digit.
- Synchronises the inputs, filters scan ghosting with a stability counter, inverse-decodes each settled pattern to a nibble, and assembles a frame.
- Delivers the frame over a valid/ready handshake.
- Used for display loopback checking and for capturing external display modules.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (width of an_n).
- STABLE_CYCLES, 8: consecutive identical synchronised samples required before capture (range 2..255).
- SYNC_STAGES, 2: flop stages on seg_n/an_n (range 2..3).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- seg_n  in  7  segments {g,f,e,d,c,b,a}; 0 = lit
- an_n  in  NUM_DIGITS  digit enables; 0 = digit driven
- digits  out  4*NUM_DIGITS  captured frame; digit i at [4i+3:4i]
- frame_valid  out  1  digits holds an unconsumed frame
- frame_ready  in  1  consumer accepts frame when high with frame_valid
- pattern_err  out  1  one-cycle pulse: settled pattern not in font
- overrun  out  1  sticky: a completed frame was dropped

Behaviour:
- Reset (reset_n low at a clk edge) sets all flops to zero except the sync chain, which is set to all ones (blank). Outputs after reset: digits=0, frame_valid=0, pattern_err=0, overrun=0. Filter state is SETTLING with count 0. Collect mask is 0.
- Reset asserted mid-frame discards the partial frame and any pending frame.
- Font, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Filter FSM operates on the synchronised sample S={an,seg}:
  - SETTLING: if S equals the previous S, count++; otherwise count=0. When count reaches STABLE_CYCLES-1 with S unchanged, perform one capture and go to LOCKED.
  - LOCKED: any change in S sets count=0 and goes to SETTLING. No further captures are made while locked.
- Capture action:
  - If an is not exactly one-hot low (blank or multi-hot), nothing happens.
  - Else, if seg is in the font, write the nibble into working slot i and set mask bit i. Recapturing a digit already in the mask overwrites its slot.
  - Else, pulse pattern_err for 1 cycle; the slot and mask are unchanged.
- Latency: a pattern stable on the pins for at least SYNC_STAGES+STABLE_CYCLES cycles is written to its working slot exactly SYNC_STAGES+STABLE_CYCLES cycles after the first pin edge.
- Frame transfer: evaluated the cycle after the mask becomes all-ones.
  - If frame_valid=0, or frame_valid&frame_ready in that cycle: copy the working slots to digits, set frame_valid=1, clear the mask.
  - Otherwise: clear the mask, leave digits untouched, set overrun.
- A capture in the same cycle as the mask clear survives: its mask bit is set in the new frame.
- frame_valid&frame_ready with no transfer pending: frame_valid goes to 0 next cycle; digits is held.
- overrun clears on an accepted handshake unless set in the same cycle (set wins).
- digits and frame_valid are stable while frame_valid=1 and frame_ready=0.

Optional Feature:
- Macro: SEVEN_SEG_READER_DP_EN.
- Defined:
  - Adds input dp_n (1 bit) and output dps (NUM_DIGITS).
  - dp_n is synchronised and included in S.
  - It is captured per digit alongside the nibble and transferred to dps with digits.
  - dps is active-high (1 = point lit) and resets to 0.
- Undefined: no dp ports; the decimal point does not affect the filter.

Decomposition:
- Package seven_seg_pkg:
  - SEG_W=7 and NIBBLE_W=4
  - the 16-entry font constant array
  - the filter FSM state enum {SETTLING, LOCKED}
- Sub-module seg_pattern_to_hex: combinational. Input 7-bit pattern; outputs 4-bit value and a hit flag. Uses the package font.
- Filter, collector and handshake live in the top module.

Test Plan:
- Hold an_n=1110, seg_n=24 for 20 cycles, then cycle through digits 1..3 with 79, 30, 0E. Result: frame_valid rises with digits=F312. The first capture lands exactly 10 cycles after the pin edge.
- Toggle seg_n every 5 cycles (less than STABLE_CYCLES) on one digit. Result: no capture, frame_valid stays 0, no pattern_err.
- Settle seg_n=7F (blank pattern) on an_n=1101. Result: pattern_err pulses once; mask bit 1 stays clear.
- Settle an_n=1100 or 1111 with seg_n=00. Result: no capture and no error.
- Complete two frames with frame_ready=0 throughout. Result: the first frame is held, overrun=1. Then assert frame_ready for 1 cycle: frame_valid=0 and overrun=0 next cycle.
- Assert reset_n=0 for 1 cycle after 3 of 4 digits are captured, then capture digit 3 only. Result: frame_valid stays 0 and the mask holds only bit 3.
